// File: rtl/noc_pkg.sv
// Shared types and constants for the 5-port NoC router switch allocator.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int SEL_W     = 3;

    typedef enum logic [SEL_W-1:0] {
        N = 3'd0,
        S = 3'd1,
        E = 3'd2,
        W = 3'd3,
        L = 3'd4
    } port_e;

    localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        arb_state_e       state;
        logic [SEL_W-1:0] owner;
        logic [SEL_W-1:0] ptr;
    } arb_dbg_t;

    // Cyclic add over port indices; both operands are expected in 0..NUM_PORTS-1.
    function automatic logic [SEL_W-1:0] port_add(input logic [SEL_W-1:0] p,
                                                  input logic [SEL_W-1:0] k);
        logic [SEL_W:0] s;
        s = {1'b0, p} + {1'b0, k};
        if (s >= 4'(NUM_PORTS)) begin
            s = s - 4'(NUM_PORTS);
        end
        return s[SEL_W-1:0];
    endfunction

endpackage

// File: rtl/noc_switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
interface noc_switch_allocator_if;
    import noc_pkg::*;

    // Handshake: input i moves a flit on a cycle where req_valid[i] and grant[i] are both 1;
    // grant is only raised when the destination's out_ready is 1, so grant alone means dequeue.
    logic [NUM_PORTS-1:0]       req_valid;
    logic [NUM_PORTS*SEL_W-1:0] req_dest;
    logic [NUM_PORTS-1:0]       req_tail;
    logic [NUM_PORTS-1:0]       out_ready;
    logic [NUM_PORTS-1:0]       grant;
    logic [NUM_PORTS*SEL_W-1:0] out_sel;
    logic [NUM_PORTS-1:0]       out_valid;
    logic [NUM_PORTS-1:0]       err;

    modport master (
        output req_valid, req_dest, req_tail, out_ready,
        input  grant, out_sel, out_valid, err
    );

    modport slave (
        input  req_valid, req_dest, req_tail, out_ready,
        output grant, out_sel, out_valid, err
    );

endinterface

// File: rtl/noc_rr_out_arbiter.sv
// Per-output round-robin arbiter that holds the output for one input from head to tail flit.
module noc_rr_out_arbiter
    import noc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 ready_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 valid_o,
    output arb_dbg_t             dbg_o
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             found;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = port_add(ptr_q, 3'(k));
            if (req_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_o   = '0;
        sel_o   = SEL_NONE;
        valid_o = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_IDLE: begin
                    if (found && ready_i) begin
                        gnt_o[winner] = 1'b1;
                        sel_o         = winner;
                        valid_o       = 1'b1;
                        ptr_d         = port_add(winner, 3'd1);
                        if (!tail_i[winner]) begin
                            state_d = ARB_LOCKED;
                            owner_d = winner;
                        end
                    end
                end
                ARB_LOCKED: begin
                    // The owner keeps the crossbar path even on bubble cycles.
                    sel_o = owner_q;
                    if (req_i[owner_q] && ready_i) begin
                        gnt_o[owner_q] = 1'b1;
                        valid_o        = 1'b1;
                        if (tail_i[owner_q]) begin
                            state_d = ARB_IDLE;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    assign dbg_o = '{state: state_q, owner: owner_q, ptr: ptr_q};

endmodule

// File: rtl/noc_switch_allocator.sv
// Switch allocator: decodes per-input destinations, runs one locking arbiter per output.
module noc_switch_allocator
    import noc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    noc_switch_allocator_if.slave         alloc_if,
    output arb_dbg_t [NUM_PORTS-1:0]      dbg_o
);

    logic [SEL_W-1:0]     dest      [NUM_PORTS];
    logic [SEL_W-1:0]     lock_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] owns_lock;
    logic [NUM_PORTS-1:0] legal;
    logic [NUM_PORTS-1:0] port_req  [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_gnt  [NUM_PORTS];
    logic [SEL_W-1:0]     port_sel  [NUM_PORTS];
    logic [NUM_PORTS-1:0] port_valid;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [NUM_PORTS-1:0] err_d, err_q;
    arb_dbg_t             arb_dbg   [NUM_PORTS];

    // An input holds at most one lock, since its destination is frozen while it holds one.
    always_comb begin
        owns_lock = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest[i]      = alloc_if.req_dest[i*SEL_W +: SEL_W];
            lock_port[i] = SEL_NONE;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (arb_dbg[o].state == ARB_LOCKED && arb_dbg[o].owner == 3'(i)) begin
                    owns_lock[i] = 1'b1;
                    lock_port[i] = 3'(o);
                end
            end
        end
    end

    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            legal[i] = (dest[i] < 3'(NUM_PORTS)) && (dest[i] != 3'(i))
                       && (!owns_lock[i] || dest[i] == lock_port[i]);
        end
        err_d = alloc_if.req_valid & ~legal;
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            port_req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_req[o][i] = alloc_if.req_valid[i] && legal[i] && (dest[i] == 3'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        noc_rr_out_arbiter u_arb (
            .clk     (clk),
            .rst     (rst),
            .req_i   (port_req[o]),
            .tail_i  (alloc_if.req_tail),
            .ready_i (alloc_if.out_ready[o]),
            .gnt_o   (port_gnt[o]),
            .sel_o   (port_sel[o]),
            .valid_o (port_valid[o]),
            .dbg_o   (arb_dbg[o])
        );
        assign alloc_if.out_sel[o*SEL_W +: SEL_W] = port_sel[o];
        assign dbg_o[o]                            = arb_dbg[o];
    end

    always_comb begin
        grant_vec = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant_vec = grant_vec | port_gnt[o];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign alloc_if.grant     = grant_vec;
    assign alloc_if.out_valid = port_valid;
    assign alloc_if.err       = err_q;

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Scenario bench for noc_switch_allocator: per-cycle expectations go through a queue.
module tb_noc_switch_allocator;

  localparam logic [2:0] NO = 3'b111;

  logic clk;
  logic rst;
  noc_pkg::arb_dbg_t [4:0] dbg;

  noc_switch_allocator_if ifc ();

  noc_switch_allocator dut (
    .clk      (clk),
    .rst      (rst),
    .alloc_if (ifc.slave),
    .dbg_o    (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];
  logic [24:0] exp_v;
  logic [24:0] got_v;

  // driver tasks
  task automatic idle_all();
    ifc.req_valid = '0;
    ifc.req_dest  = '0;
    ifc.req_tail  = '0;
    ifc.out_ready = '1;
  endtask

  task automatic drive(input int i, input logic [2:0] d, input logic t);
    ifc.req_valid[i]       = 1'b1;
    ifc.req_dest[i*3 +: 3] = d;
    ifc.req_tail[i]        = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    drive(4, 3'd0, 1'b1);
    #2;
    exp_q.push_back({5'b00000, {NO, NO, NO, NO, NO}, 5'b00000});
    got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", got_v, exp_v);
    end
    checks++;
    if (ifc.err !== 5'b00000) begin
      errors++;
      $display("FAIL reset_err: got %b expected 00000", ifc.err);
    end
    for (int o = 0; o < 5; o++) begin
      checks++;
      if (dbg[o].state !== noc_pkg::ARB_IDLE || dbg[o].ptr !== 3'd0) begin
        errors++;
        $display("FAIL reset_state o%0d: got state %b ptr %0d expected idle ptr 0",
                 o, dbg[o].state, dbg[o].ptr);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    idle_all();
    drive(4, 3'd0, 1'b1);
    exp_q.push_back({5'b10000, {NO, NO, NO, NO, 3'd4}, 5'b00001});
    #1;
    got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL single_flit: got %h expected %h", got_v, exp_v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dbg[0].state !== noc_pkg::ARB_IDLE || dbg[0].ptr !== 3'd0) begin
      errors++;
      $display("FAIL single_state: got state %b ptr %0d expected idle ptr 0",
               dbg[0].state, dbg[0].ptr);
    end
  endtask

  task automatic test_contention();
    int src;
    logic [4:0] g;
    for (int c = 0; c < 6; c++) begin
      src = 1 + (c % 3);
      g   = 5'b00001 << src;
      @(negedge clk);
      idle_all();
      drive(1, 3'd0, 1'b1);
      drive(2, 3'd0, 1'b1);
      drive(3, 3'd0, 1'b1);
      exp_q.push_back({g, {NO, NO, NO, NO, 3'(src)}, 5'b00001});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL contention c%0d: got %h expected %h", c, got_v, exp_v);
      end
      @(posedge clk);
      #1;
      checks++;
      if (dbg[0].ptr !== 3'(src + 1)) begin
        errors++;
        $display("FAIL contention_ptr c%0d: got %0d expected %0d", c, dbg[0].ptr, src + 1);
      end
    end
  endtask

  task automatic test_locking();
    logic [5:0] e_v    = 6'b001011;
    logic [5:0] e_t    = 6'b001000;
    logic [5:0] s_v    = 6'b011110;
    logic [5:0] vw_tab = 6'b011011;
    logic [4:0] g_tab  [6] = '{5'b00100, 5'b00100, 5'b00000, 5'b00100, 5'b00010, 5'b00000};
    logic [2:0] sw_tab [6] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, NO};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_all();
      if (e_v[c]) drive(2, 3'd3, e_t[c]);
      if (s_v[c]) drive(1, 3'd3, 1'b1);
      exp_q.push_back({g_tab[c], {NO, sw_tab[c], NO, NO, NO}, {1'b0, vw_tab[c], 3'b000}});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL locking c%0d: got %h expected %h", c, got_v, exp_v);
      end
      if (c == 2) begin
        checks++;
        if (dbg[3].state !== noc_pkg::ARB_LOCKED || dbg[3].owner !== 3'd2) begin
          errors++;
          $display("FAIL locking_owner: got state %b owner %0d expected locked owner 2",
                   dbg[3].state, dbg[3].owner);
        end
      end
      if (c == 3) begin
        checks++;
        if (ifc.err !== 5'b00000) begin
          errors++;
          $display("FAIL locking_err: got %b expected 00000", ifc.err);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_all();
      if (c < 3) ifc.out_ready = 5'b01111;
      drive(0, 3'd4, 1'b1);
      if (c < 3) exp_q.push_back({5'b00000, {NO, NO, NO, NO, NO}, 5'b00000});
      else       exp_q.push_back({5'b00001, {3'd0, NO, NO, NO, NO}, 5'b10000});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL backpressure c%0d: got %h expected %h", c, got_v, exp_v);
      end
      if (c >= 2) begin
        @(posedge clk);
        #1;
        checks++;
        if (dbg[4].ptr !== ((c == 3) ? 3'd1 : 3'd0)) begin
          errors++;
          $display("FAIL backpressure_ptr c%0d: got %0d expected %0d",
                   c, dbg[4].ptr, (c == 3) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [4:0] err_tab [3] = '{5'b00000, 5'b00101, 5'b00000};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_all();
      if (c == 0) begin
        drive(0, 3'd0, 1'b1);
        drive(2, 3'b110, 1'b1);
      end
      exp_q.push_back({5'b00000, {NO, NO, NO, NO, NO}, 5'b00000});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL illegal c%0d: got %h expected %h", c, got_v, exp_v);
      end
      checks++;
      if (ifc.err !== err_tab[c]) begin
        errors++;
        $display("FAIL illegal_err c%0d: got %b expected %b", c, ifc.err, err_tab[c]);
      end
    end
  endtask

  task automatic test_dest_change();
    logic [2:0] d_tab  [4] = '{3'd0, 3'd1, 3'd0, 3'd0};
    logic [3:0] v_tab      = 4'b0111;
    logic [3:0] t_tab      = 4'b0100;
    logic [4:0] g_tab  [4] = '{5'b00100, 5'b00000, 5'b00100, 5'b00000};
    logic [2:0] sn_tab [4] = '{3'd2, 3'd2, 3'd2, NO};
    logic [4:0] v_exp  [4] = '{5'b00001, 5'b00000, 5'b00001, 5'b00000};
    logic [4:0] e_exp  [4] = '{5'b00000, 5'b00000, 5'b00100, 5'b00000};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_all();
      if (v_tab[c]) drive(2, d_tab[c], t_tab[c]);
      exp_q.push_back({g_tab[c], {NO, NO, NO, NO, sn_tab[c]}, v_exp[c]});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL dest_change c%0d: got %h expected %h", c, got_v, exp_v);
      end
      checks++;
      if (ifc.err !== e_exp[c]) begin
        errors++;
        $display("FAIL dest_change_err c%0d: got %b expected %b", c, ifc.err, e_exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_all();
      drive(1, 3'd2, 1'b0);
      if (c == 1) drive(3, 3'd2, 1'b1);
      exp_q.push_back({5'b00010, {NO, NO, 3'd1, NO, NO}, 5'b00100});
      #1;
      got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
      exp_v = exp_q.pop_front();
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_lock c%0d: got %h expected %h", c, got_v, exp_v);
      end
    end
    rst = 1'b1;
    #1;
    exp_q.push_back({5'b00000, {NO, NO, NO, NO, NO}, 5'b00000});
    got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h expected %h", got_v, exp_v);
    end
    checks++;
    if (dbg[2].state !== noc_pkg::ARB_IDLE) begin
      errors++;
      $display("FAIL reset_mid_state: got %b expected idle", dbg[2].state);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_all();
    drive(3, 3'd2, 1'b1);
    exp_q.push_back({5'b01000, {NO, NO, 3'd3, NO, NO}, 5'b00100});
    #1;
    got_v = {ifc.grant, ifc.out_sel, ifc.out_valid};
    exp_v = exp_q.pop_front();
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_mid_release: got %h expected %h", got_v, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_locking();
    test_backpressure();
    test_illegal();
    test_dest_change();
    test_reset_mid();
    @(negedge clk);
    idle_all();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
